// File: rtl/seg7_count_checker.sv
// Purpose  : receive-side monitor for an active-low 7-segment counter bus; filters, decodes, checks up-count order.
// Latency  : new_pulse/value/flags update STABLE_CYCLES edges after a new pattern is first registered in seg_q.
// Backpress: none; passive observer that never stalls its source. Optional hex mode via `SEG_CHK_HEX_EN.
module seg7_count_checker #(
   parameter int STABLE_CYCLES = 4,
   parameter int CNT_W         = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic [6:0]       seg_in,
   output logic [3:0]       value,
   output logic             digit_vld,
   output logic             new_pulse,
   output logic [CNT_W-1:0] step_cnt,
   output logic             err_code,
   output logic             err_seq
);

   localparam int               HOLD_W    = $clog2(STABLE_CYCLES + 1);
   localparam logic [HOLD_W-1:0] HOLD_SAT  = HOLD_W'(STABLE_CYCLES);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(STABLE_CYCLES - 1);
   localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
   localparam logic [CNT_W-1:0]  STEP_MAX  = '1;
   localparam logic [CNT_W-1:0]  STEP_ONE  = CNT_W'(1);
   localparam logic [6:0]        SEG_BLANK = 7'h7F;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_TRACK = 2'd1,
      ST_ERROR = 2'd2
   } state_t;

   // Maps an active-high segment pattern to {hit, digit}; hit=0 for anything that is not a glyph.
   function automatic logic [4:0] decode_seg(input logic [6:0] lit);
      logic [4:0] r;
      case (lit)
         7'h3F:   r = 5'h10;
         7'h06:   r = 5'h11;
         7'h5B:   r = 5'h12;
         7'h4F:   r = 5'h13;
         7'h66:   r = 5'h14;
         7'h6D:   r = 5'h15;
         7'h7D:   r = 5'h16;
         7'h07:   r = 5'h17;
         7'h7F:   r = 5'h18;
         7'h6F:   r = 5'h19;
         7'h77:   r = 5'h1A;
         7'h7C:   r = 5'h1B;
         7'h39:   r = 5'h1C;
         7'h5E:   r = 5'h1D;
         7'h79:   r = 5'h1E;
         7'h71:   r = 5'h1F;
         default: r = 5'h00;
      endcase
      return r;
   endfunction

   logic [6:0]        seg_q;
   logic [HOLD_W-1:0] hold_cnt;
   logic              accept;
   logic              is_blank;
   logic [4:0]        dec;
   logic              dec_hit;
   logic [3:0]        dec_digit;
   logic              digit_ok;
   logic [3:0]        succ_digit;

   state_t            state_q;
   state_t            state_nxt;
   logic [3:0]        ref_q;
   logic [3:0]        ref_nxt;
   logic [3:0]        value_nxt;
   logic              vld_nxt;
   logic              pulse_nxt;
   logic [CNT_W-1:0]  step_nxt;
   logic              err_code_nxt;
   logic              err_seq_nxt;

   // Input register and hold counter: restart on any change of the registered pattern, saturate once stable.
   always_ff @(posedge clk) begin
      if (!reset) begin
         seg_q    <= SEG_BLANK;
         hold_cnt <= '0;
      end else begin
         seg_q <= seg_in;
         if (seg_in != seg_q) begin
            hold_cnt <= '0;
         end else if (hold_cnt != HOLD_SAT) begin
            hold_cnt <= hold_cnt + HOLD_ONE;
         end
      end
   end

   // The edge that lifts the hold counter to saturation is the single acceptance edge of a stable pattern;
   // saturation then blocks re-acceptance until the pattern changes (a dropped accept is never replayed).
   assign accept    = (seg_in == seg_q) && (hold_cnt == HOLD_LAST);
   assign is_blank  = (seg_q == SEG_BLANK);
   assign dec       = decode_seg(~seg_q);
   assign dec_hit   = dec[4];
   assign dec_digit = dec[3:0];

`ifdef SEG_CHK_HEX_EN
   assign digit_ok   = dec_hit;
   assign succ_digit = ref_q + 4'd1;
`else
   assign digit_ok   = dec_hit && (dec_digit <= 4'd9);
   assign succ_digit = (ref_q == 4'd9) ? 4'd0 : ref_q + 4'd1;
`endif

   // FSM state register.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_nxt;
      end
   end

   // Next-state and output logic: clear outranks acceptance, blanks and bad glyphs bypass the sequence check.
   always_comb begin
      state_nxt    = state_q;
      ref_nxt      = ref_q;
      value_nxt    = value;
      vld_nxt      = digit_vld;
      pulse_nxt    = 1'b0;
      step_nxt     = step_cnt;
      err_code_nxt = err_code;
      err_seq_nxt  = err_seq;

      if (clear) begin
         state_nxt    = ST_IDLE;
         ref_nxt      = 4'd0;
         vld_nxt      = 1'b0;
         step_nxt     = '0;
         err_code_nxt = 1'b0;
         err_seq_nxt  = 1'b0;
      end else if (accept) begin
         pulse_nxt = 1'b1;
         if (is_blank) begin
            vld_nxt = 1'b0;
         end else if (!digit_ok) begin
            err_code_nxt = 1'b1;
            vld_nxt      = 1'b0;
         end else begin
            value_nxt = dec_digit;
            vld_nxt   = 1'b1;
            case (state_q)
               ST_IDLE: begin
                  ref_nxt   = dec_digit;
                  state_nxt = ST_TRACK;
               end
               ST_TRACK: begin
                  // Successor test comes first so that the wrap to 0 counts as a step, not a restart.
                  if (dec_digit == succ_digit) begin
                     if (step_cnt != STEP_MAX) begin
                        step_nxt = step_cnt + STEP_ONE;
                     end
                     ref_nxt = dec_digit;
                  end else if (dec_digit == 4'd0) begin
                     ref_nxt = 4'd0;
                  end else begin
                     err_seq_nxt = 1'b1;
                     state_nxt   = ST_ERROR;
                  end
               end
               ST_ERROR: begin
                  state_nxt = ST_ERROR;
               end
               default: begin
                  state_nxt = ST_IDLE;
               end
            endcase
         end
      end
   end

   // Output and reference-digit registers.
   always_ff @(posedge clk) begin
      if (!reset) begin
         ref_q     <= 4'd0;
         value     <= 4'd0;
         digit_vld <= 1'b0;
         new_pulse <= 1'b0;
         step_cnt  <= '0;
         err_code  <= 1'b0;
         err_seq   <= 1'b0;
      end else begin
         ref_q     <= ref_nxt;
         value     <= value_nxt;
         digit_vld <= vld_nxt;
         new_pulse <= pulse_nxt;
         step_cnt  <= step_nxt;
         err_code  <= err_code_nxt;
         err_seq   <= err_seq_nxt;
      end
   end

endmodule

// File: tb/tb_seg7_count_checker.sv
// Purpose  : scoreboard bench for seg7_count_checker with a digit-level reference model.
// Latency  : expected events are stamped with the edge on which they must appear.
// Backpress: none; the monitor compares every cycle against the last expected snapshot.
module tb_seg7_count_checker;

   localparam int S  = 4;
   localparam int CW = 8;
`ifdef SEG_CHK_HEX_EN
   localparam int MOD = 16;
`else
   localparam int MOD = 10;
`endif

   localparam logic [6:0] ACT [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                       7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

   logic          clk = 1'b0;
   logic          reset;
   logic          clear;
   logic [6:0]    seg_in;
   logic [3:0]    value;
   logic          digit_vld;
   logic          new_pulse;
   logic [CW-1:0] step_cnt;
   logic          err_code;
   logic          err_seq;

   seg7_count_checker #(.STABLE_CYCLES(S), .CNT_W(CW)) dut (
      .clk       (clk),
      .reset     (reset),
      .clear     (clear),
      .seg_in    (seg_in),
      .value     (value),
      .digit_vld (digit_vld),
      .new_pulse (new_pulse),
      .step_cnt  (step_cnt),
      .err_code  (err_code),
      .err_seq   (err_seq)
   );

   always #5 clk = ~clk;

   int edge_cnt = 0;
   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   // kind: 0 = accepted pattern (pulse), 1 = clear, 2 = reset
   typedef struct {
      int            edge_no;
      int            kind;
      logic [3:0]    value;
      logic          vld;
      logic [CW-1:0] step;
      logic          ec;
      logic          es;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_err    = 0;

   // Reference model state, digit level.
   int   m_value = 0;
   bit   m_vld = 0, m_ec = 0, m_es = 0, m_track = 0, m_broken = 0;
   int   m_step = 0;
   int   m_ref = 0;
   logic [6:0] last_drv = 7'h7F;
   logic [6:0] last_acc = 7'h7F;

   function automatic logic [6:0] seg_of(input int d);
      return ~ACT[d];
   endfunction

   function automatic int lookup(input logic [6:0] seg);
      logic [6:0] lit;
      lit = ~seg;
      for (int i = 0; i < 16; i++) begin
         if (lit == ACT[i]) return i;
      end
      return -1;
   endfunction

   task automatic push(input int e, input int k);
      exp_t r;
      r.edge_no = e;
      r.kind    = k;
      r.value   = 4'(m_value);
      r.vld     = m_vld;
      r.step    = CW'(m_step);
      r.ec      = m_ec;
      r.es      = m_es;
      sb.push_back(r);
   endtask

   task automatic model_accept(input logic [6:0] p, input int e);
      int d;
      if (p == 7'h7F) begin
         m_vld = 0;
      end else begin
         d = lookup(p);
         if (d < 0 || d >= MOD) begin
            m_ec  = 1;
            m_vld = 0;
         end else begin
            m_value = d;
            m_vld   = 1;
            if (m_broken) begin
               m_broken = 1;
            end else if (!m_track) begin
               m_track = 1;
               m_ref   = d;
            end else if (d == (m_ref + 1) % MOD) begin
               if (m_step < (2 ** CW) - 1) m_step++;
               m_ref = d;
            end else if (d == 0) begin
               m_ref = 0;
            end else begin
               m_es     = 1;
               m_broken = 1;
               m_track  = 0;
            end
         end
      end
      push(e, 0);
   endtask

   task automatic model_clear(input int e);
      m_vld = 0; m_ec = 0; m_es = 0; m_step = 0; m_track = 0; m_broken = 0; m_ref = 0;
      push(e, 1);
   endtask

   // Hold pattern p on seg_in for n edges; c >= 0 asserts clear on the c-th edge of the run.
   // A run of at least S+1 samples is accepted on its (S+1)-th edge unless clear lands on that edge.
   task automatic run(input logic [6:0] p, input int n, input int c);
      int  e0, acc;
      bit  taken;
      e0    = edge_cnt + 1;
      acc   = (n >= S + 1) ? e0 + S : -1;
      taken = 0;
      if (c >= 0 && acc >= 0 && e0 + c == acc) begin
         model_clear(acc);
      end else begin
         if (c >= 0 && (acc < 0 || e0 + c < acc)) model_clear(e0 + c);
         if (acc >= 0) begin
            model_accept(p, acc);
            taken = 1;
         end
         if (c >= 0 && acc >= 0 && e0 + c > acc) model_clear(e0 + c);
      end
      for (int i = 0; i < n; i++) begin
         seg_in = p;
         clear  = (i == c);
         @(posedge clk);
         #1;
      end
      clear    = 1'b0;
      last_drv = p;
      if (taken) last_acc = p;
   endtask

   task automatic do_reset(input int n);
      for (int i = 0; i < n; i++) begin
         reset = 1'b0;
         clear = 1'b0;
         m_value = 0; m_vld = 0; m_ec = 0; m_es = 0; m_step = 0;
         m_track = 0; m_broken = 0; m_ref = 0;
         push(edge_cnt + 1, 2);
         @(posedge clk);
         #1;
      end
      reset    = 1'b1;
      last_drv = 7'h7F;
      last_acc = 7'h7F;
   endtask

   // Monitor: applies the expected event for this edge, then compares every output.
   exp_t          mon_r;
   bit            mon_on = 0;
   bit            pulse_exp;
   logic [3:0]    cur_value = '0;
   logic          cur_vld = 0, cur_ec = 0, cur_es = 0;
   logic [CW-1:0] cur_step = '0;

   always @(negedge clk) begin
      pulse_exp = 1'b0;
      while (sb.size() > 0 && sb[0].edge_no < edge_cnt) begin
         mon_r = sb.pop_front();
         n_checks++;
         n_err++;
         $display("FAIL missed_event at edge %0d: got nothing, required kind %0d at edge %0d",
                  edge_cnt, mon_r.kind, mon_r.edge_no);
      end
      if (sb.size() > 0 && sb[0].edge_no == edge_cnt) begin
         mon_r = sb.pop_front();
         if (mon_r.kind == 0) begin
            pulse_exp = 1'b1;
            cur_value = mon_r.value;
            cur_vld   = mon_r.vld;
            cur_step  = mon_r.step;
            cur_ec    = mon_r.ec;
            cur_es    = mon_r.es;
         end else if (mon_r.kind == 1) begin
            cur_vld  = 1'b0;
            cur_step = '0;
            cur_ec   = 1'b0;
            cur_es   = 1'b0;
         end else begin
            mon_on    = 1;
            cur_value = '0;
            cur_vld   = 1'b0;
            cur_step  = '0;
            cur_ec    = 1'b0;
            cur_es    = 1'b0;
         end
      end
      if (mon_on) begin
         n_checks++;
         if ({new_pulse, value, digit_vld, step_cnt, err_code, err_seq} !==
             {pulse_exp, cur_value, cur_vld, cur_step, cur_ec, cur_es}) begin
            n_err++;
            $display("FAIL outputs edge=%0d got pulse=%b value=%h vld=%b step=%0d ec=%b es=%b required pulse=%b value=%h vld=%b step=%0d ec=%b es=%b",
                     edge_cnt, new_pulse, value, digit_vld, step_cnt, err_code, err_seq,
                     pulse_exp, cur_value, cur_vld, cur_step, cur_ec, cur_es);
         end
      end
   end

   initial begin
      logic [6:0] p;
      int         r, n, c;
      reset  = 1'b0;
      clear  = 1'b0;
      seg_in = ~7'h3F;

      // Reset with 0 on the bus, then the steady 0 is accepted on the 5th edge after release.
      do_reset(3);
      run(~7'h3F, 10, -1);

      // Full count with wrap to 0.
      for (int d = 1; d < MOD; d++) run(seg_of(d), 10, -1);
      run(seg_of(0), 10, -1);

      // Glitch at 3 is filtered; 3 -> 1 is a sequence error; later digits still decode.
      run(seg_of(1), 8, -1);
      run(seg_of(2), 8, -1);
      run(seg_of(3), 8, -1);
      run(seg_of(4), 2, -1);
      run(seg_of(1), 10, -1);
      run(seg_of(2), 10, -1);

      // All-lit is an 8; 7'h55 is not a glyph; clear wipes flags after the accept.
      run(7'h00, 10, -1);
      run(7'h55, 10, 7);
      run(seg_of(3), 8, -1);

      // 8, 9, 0 then A (illegal glyph in decimal mode, bad step in hex mode).
      run(seg_of(8), 8, 2);
      run(seg_of(9), 8, -1);
      run(seg_of(0), 8, -1);
      run(seg_of(10), 8, -1);

      // Clear lands exactly on the acceptance edge of 6: pulse dropped, 7 reloads in IDLE.
      run(seg_of(5), 8, 1);
      run(seg_of(6), 8, S);
      run(seg_of(7), 8, -1);
      run(seg_of(8), 8, -1);

      // Long up-count drives step_cnt into saturation.
      run(seg_of(0), 7, 0);
      for (int i = 1; i <= 270; i++) run(seg_of(i % MOD), 6, -1);

      // Reset mid-filter, then the same steady pattern is accepted afresh.
      run(seg_of(4), 2, -1);
      do_reset(2);
      run(seg_of(4), 8, -1);
      run(seg_of(5), 8, -1);

      // Randomized runs: mostly legal steps, some restarts, blanks, junk, glitches, clears and resets.
      for (int k = 0; k < 250; k++) begin
         r = $urandom_range(0, 99);
         if (r < 60)      p = seg_of((m_ref + 1) % MOD);
         else if (r < 70) p = seg_of(0);
         else if (r < 82) p = seg_of($urandom_range(0, 15));
         else if (r < 88) p = 7'h7F;
         else             p = 7'($urandom);
         while (p == last_drv || p == last_acc) p = 7'($urandom);
         n = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 3) : $urandom_range(6, 12);
         c = -1;
         if ($urandom_range(0, 9) == 0) begin
            c = (n > S && $urandom_range(0, 1) == 1) ? S : $urandom_range(0, n - 1);
         end
         if ($urandom_range(0, 39) == 0) begin
            do_reset($urandom_range(1, 3));
            while (p == last_drv || p == last_acc) p = 7'($urandom);
         end
         run(p, n, c);
      end

      @(negedge clk);
      @(negedge clk);
      n_checks++;
      if (sb.size() != 0) begin
         n_err++;
         $display("FAIL scoreboard_drain: got %0d pending events, required 0", sb.size());
      end
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
